fnd_scan_controller: RTL
========================

# fnd_scan_controller

Time-multiplexed scan controller for the 4-digit common-anode FND on the counter board. It shares the single segment bus among four digits, one digit per scan slot, and converts the counter value to per-digit segment patterns. A frame-start snapshot keeps digits from tearing, and a guard interval between slots suppresses ghosting. It sits between the counter datapath (count value) and the board's FND pins.

## Interface

Parameters:
- SCAN_DIV, 100_000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); minimum 4
- GUARD, 2, blank cycles at the start of each slot; 0 ≤ GUARD < SCAN_DIV

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- count_in  input  14  binary value to display, nominal 0–9999
- blank_lz  input  1  1 = blank leading zeros on digits 3..1
- dp_mask  input  4  1 = light the decimal point of digit n (bit n)
- fnd_com  output  4  digit enables, active-low; bit 0 = rightmost (ones) digit
- fnd_data  output  8  segments, active-low; [7]=dp, [6:0]=g..a

## Operation

- Reset values (asynchronous; all outputs registered):
  - fnd_com = 4'b1111, fnd_data = 8'hFF
  - prescaler = 0, digit_sel = 3, snapshot = 0
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - slot_tick is asserted for one cycle when prescaler = SCAN_DIV-1.
- On slot_tick:
  - digit_sel advances 0→1→2→3→0. The first tick after reset selects digit 0.
  - When digit_sel wraps to 0, snapshot ← min(count_in, 9999). The clamp is saturating: any value ≥ 10000 displays as 9999.
  - The ones/tens/hundreds/thousands digits are derived from snapshot only. count_in changes mid-frame are not visible until the next frame.
- Slot FSM states:
  - BLANK: fnd_com = 1111 for GUARD cycles after the tick.
  - DRIVE: fnd_com = ~(1 << digit_sel) for the rest of the slot.
  - GUARD = 0 means DRIVE is entered directly.
- Segment encoding fnd_data[6:0] for digits 0–9: C0,F9,A4,B0,99,92,82,F8,80,90 (low 7 bits).
- fnd_data[7] = ~dp_mask[digit_sel], sampled live.
- fnd_data is updated on the tick cycle, so it is stable throughout BLANK and DRIVE.
- Leading-zero blanking: when blank_lz = 1, digit n (n = 3..1) is zero-blanked if the digit and every higher digit are 0.
  - A zero-blanked digit drives fnd_data[6:0] = 7'h7F; its dp still follows dp_mask.
  - Digit 0 is never blanked.
  - blank_lz is sampled live at each tick.
- Reset asserted mid-slot forces all reset values immediately. After release, operation restarts from digit_sel = 3, prescaler = 0.

## Timing

- The first tick occurs SCAN_DIV cycles after reset release. fnd_com goes low GUARD+1 cycles after the tick edge.
- Slot period = SCAN_DIV cycles. Frame period = 4·SCAN_DIV cycles.
- DRIVE length = SCAN_DIV − GUARD cycles.
- count_in-to-display latency: up to 4·SCAN_DIV cycles (next frame start) plus GUARD+1 cycles.
- No two fnd_com bits are ever low simultaneously. Every slot transition passes through 1111 when GUARD ≥ 1.
- Snapshot and digit advance occur in the same cycle. There is no one-slot stale digit at frame start.

## Test plan

All scenarios use SCAN_DIV = 10, GUARD = 2.

- **Reset:** rst high → fnd_com = 1111, fnd_data = FF. After release, first tick at cycle 10; com = 1111 for 2 cycles, then 1110. With count_in = 0, data = C0 (dp off).
- **Scan order:** count_in = 1234, blank_lz = 0, dp_mask = 0. Per slot: (com 1110, data 99) → (1101, B0) → (1011, A4) → (0111, F9). Each slot has 2 blank cycles; the sequence repeats every 40 cycles.
- **Snapshot:** count_in changes 1234→5678 while digit 1 is driven → digits 2 and 3 still show A4 and F9. The next frame shows 80, F8, 82, 92.
- **Leading-zero blanking:**
  - blank_lz = 1, count_in = 7 → digit 0 = F8; digits 1..3 = FF.
  - count_in = 0 → digit 0 = C0, others FF.
  - count_in = 1005 → 92, C0, C0, F9 (no blanking).
- **Saturation and dp:**
  - count_in = 12000 → all digits 90.
  - dp_mask = 0100 with count_in = 1234 → digit 2 data = 24; all others have bit 7 = 1.
- **Reset mid-frame:** assert rst during digit 2 DRIVE → com 1111, data FF in the same cycle. After release, restart at digit 0 after 10 + 2 cycles.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Four-digit common-anode FND scan controller: shares one segment bus across
// four digits, with a frame-start snapshot of the count and a blank guard per slot.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100_000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] count_in,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam int              GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0]   GUARD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [13:0]     MAX_VALUE  = 14'd9999;

  // S_IDLE covers the span between reset release and the first slot tick.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [GW-1:0] guard_cnt;
  logic [GW-1:0] guard_n;
  logic [PW-1:0] prescaler;
  logic          slot_tick;
  logic [1:0]    digit_sel;
  logic [1:0]    sel_n;
  logic [13:0]   snapshot;
  logic [13:0]   clamped;
  logic [13:0]   snap_src;
  logic [15:0]   bcd;
  logic [3:0]    dig [4];
  logic          zero_blank [4];
  logic [3:0]    cur_dig;
  logic          cur_blank;
  logic [7:0]    data_n;
  logic [3:0]    com_n;

  // Binary to packed BCD (shift-and-add-3), enough for values up to 9999.
  function automatic logic [15:0] to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14 + 4*d +: 4] > 4'd4) begin
          sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  // Active-low g..a pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign slot_tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (slot_tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Digit content for the slot about to start; at frame start it comes from the
  // freshly clamped count so the ones digit is never a frame behind.
  always_comb begin
    sel_n    = digit_sel + 2'd1;
    clamped  = (count_in > MAX_VALUE) ? MAX_VALUE : count_in;
    snap_src = (sel_n == 2'd0) ? clamped : snapshot;
    bcd      = to_bcd(snap_src);
    dig[0]   = bcd[3:0];
    dig[1]   = bcd[7:4];
    dig[2]   = bcd[11:8];
    dig[3]   = bcd[15:12];
    zero_blank[3] = blank_lz && (dig[3] == 4'd0);
    zero_blank[2] = zero_blank[3] && (dig[2] == 4'd0);
    zero_blank[1] = zero_blank[2] && (dig[1] == 4'd0);
    zero_blank[0] = 1'b0;
    cur_dig   = dig[sel_n];
    cur_blank = zero_blank[sel_n];
    data_n    = {~dp_mask[sel_n], cur_blank ? 7'h7F : seg7(cur_dig)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel <= 2'd3;
      snapshot  <= '0;
      fnd_data  <= 8'hFF;
    end else if (slot_tick) begin
      digit_sel <= sel_n;
      snapshot  <= snap_src;
      fnd_data  <= data_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      guard_cnt <= '0;
      fnd_com   <= 4'b1111;
    end else begin
      state     <= state_n;
      guard_cnt <= guard_n;
      fnd_com   <= com_n;
    end
  end

  always_comb begin
    state_n = state;
    guard_n = guard_cnt;
    com_n   = fnd_com;
    if (slot_tick) begin
      guard_n = '0;
      if (GUARD == 0) begin
        state_n = S_DRIVE;
        com_n   = ~(4'b0001 << sel_n);
      end else begin
        state_n = S_BLANK;
        com_n   = 4'b1111;
      end
    end else begin
      case (state)
        S_BLANK: begin
          com_n = 4'b1111;
          if (guard_cnt == GUARD_LAST) begin
            state_n = S_DRIVE;
            com_n   = ~(4'b0001 << digit_sel);
          end else begin
            guard_n = guard_cnt + GW'(1);
          end
        end
        S_DRIVE: com_n = ~(4'b0001 << digit_sel);
        default: com_n = 4'b1111;
      endcase
    end
  end

endmodule
